// File: rtl/fft2d_out_collector_if.sv
// Stream bundle for fft2d_out_collector: FFT bus capture inputs and the
// valid/ready complex-pair output seen by the consumer.
interface fft2d_out_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2N      = 6
);
    logic                  i_fft_start;
    logic                  i_fft_out_valid;
    logic [DATA_WIDTH-1:0] i_fft_data;
    logic                  i_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_re;
    logic [DATA_WIDTH-1:0] o_im;
    logic [LOG2N-1:0]      o_row;
    logic [LOG2N-1:0]      o_col;
    logic                  o_frame_done;
    logic                  o_overflow;
    logic                  o_busy;

    modport slave (
        input  i_fft_start, i_fft_out_valid, i_fft_data, i_ready,
        output o_valid, o_re, o_im, o_row, o_col, o_frame_done, o_overflow, o_busy
    );

    modport master (
        output i_fft_start, i_fft_out_valid, i_fft_data, i_ready,
        input  o_valid, o_re, o_im, o_row, o_col, o_frame_done, o_overflow, o_busy
    );
endinterface

// File: rtl/fft2d_out_collector.sv
// Captures FFT2D result words, pairs them (real then imaginary) with a row/col
// index and buffers them in a FWFT FIFO. Define FFT2D_OUT_BITREV_EN for bit-reversed indices.
module fft2d_out_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2N      = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 i_fft_base_clock,
    input  logic                 i_fft_reset_n,
    fft2d_out_collector_if.slave bus
);
    localparam int IDX_W = 2 * LOG2N;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, COLLECT, DRAIN} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
        logic [IDX_W-1:0]      idx;
    } pair_t;

    state_e                state_q;
    logic                  half_q;
    logic [DATA_WIDTH-1:0] re_q;
    logic [IDX_W-1:0]      k_q;
    logic                  overflow_q;
    logic                  frame_done_q;

    pair_t                 mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  accept;
    logic                  pair_done;
    logic                  fifo_valid;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    pair_t                 head;
    logic [LOG2N-1:0]      row_nat;
    logic [LOG2N-1:0]      col_nat;

    // A completed pair may enter a full FIFO only when a pop frees the slot on the same edge.
    always_comb begin
        accept     = bus.i_fft_out_valid && (state_q == ARMED || state_q == COLLECT);
        pair_done  = accept && half_q;
        fifo_valid = (count_q != '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        pop        = fifo_valid && bus.i_ready;
        push       = pair_done && (!fifo_full || pop);
    end

    always_ff @(posedge i_fft_base_clock) begin
        if (!i_fft_reset_n) begin
            state_q      <= IDLE;
            half_q       <= 1'b0;
            re_q         <= '0;
            k_q          <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_fft_start) begin
                        state_q    <= ARMED;
                        overflow_q <= 1'b0;
                        k_q        <= '0;
                        half_q     <= 1'b0;
                    end
                end
                ARMED:   if (accept) state_q <= COLLECT;
                COLLECT: if (pair_done && k_q == LAST_IDX) state_q <= DRAIN;
                DRAIN: begin
                    if (!fifo_valid || (pop && count_q == CNT_W'(1))) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                half_q <= !half_q;
                if (!half_q) re_q <= bus.i_fft_data;
            end
            // Dropped pairs still consume their index so later pairs stay correctly tagged.
            if (pair_done) begin
                k_q <= k_q + IDX_W'(1);
                if (!push) overflow_q <= 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array carries no reset; occupancy is tracked by count_q and
    // the head is masked while empty, so stale entries are never visible.
    always_ff @(posedge i_fft_base_clock) begin
        if (push) mem_q[wr_ptr_q] <= '{re: re_q, im: bus.i_fft_data, idx: k_q};
    end

    always_comb begin
        head    = fifo_valid ? mem_q[rd_ptr_q] : '0;
        row_nat = head.idx[IDX_W-1:LOG2N];
        col_nat = head.idx[LOG2N-1:0];
    end

`ifdef FFT2D_OUT_BITREV_EN
    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    assign bus.o_row = bit_reverse(row_nat);
    assign bus.o_col = bit_reverse(col_nat);
`else
    assign bus.o_row = row_nat;
    assign bus.o_col = col_nat;
`endif

    assign bus.o_valid      = fifo_valid;
    assign bus.o_re         = head.re;
    assign bus.o_im         = head.im;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fft2d_out_collector.sv
// Scoreboard bench for fft2d_out_collector: expected pairs are queued as the bus
// words are driven and compared as the consumer pops them.
module tb_fft2d_out_collector;
    localparam int DATA_WIDTH = 16;
    localparam int LOG2N      = 6;
    localparam int FIFO_DEPTH = 16;
    localparam int N_PAIRS    = 1 << (2 * LOG2N);
    localparam int VEC_W      = 2 * DATA_WIDTH + 2 * LOG2N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft2d_out_collector_if #(.DATA_WIDTH(DATA_WIDTH), .LOG2N(LOG2N)) bus ();

    fft2d_out_collector #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2N      (LOG2N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_fft_base_clock (clk),
        .i_fft_reset_n    (rst_n),
        .bus              (bus)
    );

    int               vectors_applied = 0;
    int               miscompares     = 0;
    int               frame_done_cnt  = 0;
    int               pops_in_frame   = 0;
    int               done_before;
    logic [VEC_W-1:0] sb_q[$];
    logic [VEC_W-1:0] mon_got;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Pair k carries re = 2k+1 and im = -(2k+1), so pair 0 is 0x0001 / 0xFFFF.
    function automatic logic [VEC_W-1:0] expected_pair(input int k);
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
        logic [LOG2N-1:0]      row;
        logic [LOG2N-1:0]      col;
        re  = DATA_WIDTH'(2 * k + 1);
        im  = DATA_WIDTH'(0) - re;
        row = LOG2N'(k >> LOG2N);
        col = LOG2N'(k);
`ifdef FFT2D_OUT_BITREV_EN
        row = rev(row);
        col = rev(col);
`endif
        return {re, im, row, col};
    endfunction

    // mode 0: always ready; 1: never ready; 2: stall until full, then ready on imaginary-word cycles
    function automatic logic ready_for(input int mode, input int k, input bit imag);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            default: return (k >= FIFO_DEPTH) && imag;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            pops_in_frame = 0;
        end else begin
            if (bus.i_fft_start && !bus.o_busy) pops_in_frame = 0;
            if (bus.o_frame_done) frame_done_cnt++;
            if (bus.o_valid && bus.i_ready) begin
                mon_got = {bus.o_re, bus.o_im, bus.o_row, bus.o_col};
                check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) check("pair", mon_got, sb_q.pop_front());
                if (pops_in_frame == 0)
                    check("first_pair", mon_got, {16'h0001, 16'hFFFF, 12'h000});
                if (pops_in_frame == 64)
`ifdef FFT2D_OUT_BITREV_EN
                    check("k64_index", {bus.o_row, bus.o_col}, 12'h800);
`else
                    check("k64_index", {bus.o_row, bus.o_col}, 12'h040);
`endif
                if (pops_in_frame == N_PAIRS - 1)
                    check("last_index", {bus.o_row, bus.o_col}, 12'hFFF);
                pops_in_frame++;
            end
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        bus.i_fft_start = 1'b1;
        @(posedge clk); #1;
        bus.i_fft_start = 1'b0;
    endtask

    task automatic drive_frame(input int n_pairs, input int rdy_mode, input int keep_limit,
                               input int start_glitch_at);
        for (int k = 0; k < n_pairs; k++) begin
            logic [VEC_W-1:0] exp_v;
            exp_v = expected_pair(k);
            @(posedge clk); #1;
            bus.i_fft_out_valid = 1'b1;
            bus.i_fft_data      = exp_v[VEC_W-1 -: DATA_WIDTH];
            bus.i_fft_start     = (k == start_glitch_at);
            bus.i_ready         = ready_for(rdy_mode, k, 1'b0);
            @(posedge clk); #1;
            bus.i_fft_start     = 1'b0;
            bus.i_fft_data      = exp_v[VEC_W-DATA_WIDTH-1 -: DATA_WIDTH];
            bus.i_ready         = ready_for(rdy_mode, k, 1'b1);
            if (k < keep_limit) sb_q.push_back(exp_v);
        end
        @(posedge clk); #1;
        bus.i_fft_out_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (bus.o_frame_done) begin
                seen = 1;
                check({tag, "_busy_at_done"}, bus.o_busy, 0);
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, bus.o_frame_done, 0);
    endtask

    initial begin
        bus.i_fft_start     = 1'b0;
        bus.i_fft_out_valid = 1'b0;
        bus.i_fft_data      = '0;
        bus.i_ready         = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid",      bus.o_valid,      0);
        check("rst_re",         bus.o_re,         0);
        check("rst_im",         bus.o_im,         0);
        check("rst_row",        bus.o_row,        0);
        check("rst_col",        bus.o_col,        0);
        check("rst_frame_done", bus.o_frame_done, 0);
        check("rst_overflow",   bus.o_overflow,   0);
        check("rst_busy",       bus.o_busy,       0);

        // A lone bus word in IDLE must not be captured nor flip the half flag.
        @(posedge clk); #1;
        bus.i_fft_out_valid = 1'b1;
        bus.i_fft_data      = 16'h1234;
        @(posedge clk); #1;
        bus.i_fft_out_valid = 1'b0;
        @(negedge clk);
        check("idle_word_busy",  bus.o_busy,  0);
        check("idle_word_valid", bus.o_valid, 0);

        // Frame A: free-flowing consumer, spurious start mid-frame.
        bus.i_ready = 1'b1;
        start_frame();
        done_before = frame_done_cnt;
        drive_frame(N_PAIRS, 0, N_PAIRS, 2000);
        wait_frame_done("frameA", 200);
        check("frameA_done_count", frame_done_cnt - done_before, 1);
        check("frameA_overflow",   bus.o_overflow, 0);
        check("frameA_sb_empty",   sb_q.size(), 0);
        check("frameA_pops",       pops_in_frame, N_PAIRS);

        // Frame B: consumer stalled all frame; only the first FIFO_DEPTH pairs survive.
        start_frame();
        done_before = frame_done_cnt;
        drive_frame(N_PAIRS, 1, FIFO_DEPTH, -1);
        @(negedge clk);
        check("frameB_overflow", bus.o_overflow, 1);
        check("frameB_busy",     bus.o_busy, 1);
        check("frameB_retained", sb_q.size(), FIFO_DEPTH);
        check("frameB_head_idx", {bus.o_row, bus.o_col}, 12'h000);
        // Release the consumer while driving words that DRAIN must ignore.
        @(posedge clk); #1;
        bus.i_ready         = 1'b1;
        bus.i_fft_out_valid = 1'b1;
        bus.i_fft_data      = 16'hDEAD;
        repeat (4) @(posedge clk);
        #1 bus.i_fft_out_valid = 1'b0;
        wait_frame_done("frameB", 200);
        check("frameB_done_count", frame_done_cnt - done_before, 1);
        check("frameB_sb_empty",   sb_q.size(), 0);
        check("frameB_pops",       pops_in_frame, FIFO_DEPTH);

        // Frame C: fill the FIFO, then pop exactly on each push edge while full.
        start_frame();
        done_before = frame_done_cnt;
        drive_frame(N_PAIRS, 2, N_PAIRS, -1);
        check("frameC_overflow", bus.o_overflow, 0);
        wait_frame_done("frameC", 200);
        check("frameC_done_count", frame_done_cnt - done_before, 1);
        check("frameC_sb_empty",   sb_q.size(), 0);
        check("frameC_pops",       pops_in_frame, N_PAIRS);

        // Reset mid-COLLECT after 100 pairs, then a clean frame restarts at index 0.
        bus.i_ready = 1'b1;
        start_frame();
        drive_frame(100, 0, 100, -1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy",  bus.o_busy,  0);
        check("midrst_valid", bus.o_valid, 0);
        start_frame();
        done_before = frame_done_cnt;
        drive_frame(N_PAIRS, 0, N_PAIRS, -1);
        wait_frame_done("frameD", 200);
        check("frameD_done_count", frame_done_cnt - done_before, 1);
        check("frameD_overflow",   bus.o_overflow, 0);
        check("frameD_sb_empty",   sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
